// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer.
// The PAUSED encoding exists only when GAME_SEQUENCER_PAUSE_EN is defined.
package game_pkg;

    localparam int LIVES_DEFAULT       = 3;
    localparam int SERVE_TICKS_DEFAULT = 60;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESPAWN = 3'd1,
        ST_SERVE   = 3'd2,
        ST_PLAY    = 3'd3,
        ST_LOST    = 3'd4,
        ST_OVER    = 3'd5,
`ifdef GAME_SEQUENCER_PAUSE_EN
        ST_WON     = 3'd6,
        ST_PAUSED  = 3'd7
`else
        ST_WON     = 3'd6
`endif
    } game_state_t;

endpackage

// File: rtl/game_sequencer_edge_rise.sv
// Registered rising-edge detector; the sample register resets to RST_VAL so a
// level already high at reset release produces no edge.
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_edge
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!reset) r_q <= RST_VAL;
        else        r_q <= i_d;
    end

    assign o_edge = i_d & ~r_q;

endmodule

// File: rtl/game_sequencer.sv
// Breakout-style game flow controller: serve delay, lives, win/lose states.
// Define GAME_SEQUENCER_PAUSE_EN to add the pause input and PAUSED state.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES       = LIVES_DEFAULT,
    parameter int SERVE_TICKS = SERVE_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       ballOut,
    input  logic       bricksCleared,
`ifdef GAME_SEQUENCER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       ballEnable,
    output logic       ballRespawn,
    output logic [1:0] lives,
    output logic       gameOver,
    output logic       gameWon,
    output logic [2:0] gameState
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

    game_state_t r_state, w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lives;
    logic        r_en, r_resp, r_over, r_won;
    logic        w_start_edge;
    logic        w_pause_edge;

    edge_rise #(.RST_VAL(1'b1)) u_start_edge (
        .clk(clk), .reset(reset), .i_d(start), .o_edge(w_start_edge)
    );

`ifdef GAME_SEQUENCER_PAUSE_EN
    edge_rise #(.RST_VAL(1'b1)) u_pause_edge (
        .clk(clk), .reset(reset), .i_d(pause), .o_edge(w_pause_edge)
    );
`else
    assign w_pause_edge = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_edge) w_next = ST_RESPAWN;
            ST_RESPAWN: w_next = ST_SERVE;
            ST_SERVE:   if (tick && r_cnt == SERVE_LAST) w_next = ST_PLAY;
            ST_PLAY: begin
                if (bricksCleared)     w_next = ST_WON;
                else if (ballOut)      w_next = ST_LOST;
`ifdef GAME_SEQUENCER_PAUSE_EN
                else if (w_pause_edge) w_next = ST_PAUSED;
`endif
            end
            ST_LOST:    w_next = (r_lives <= 2'd1) ? ST_OVER : ST_RESPAWN;
            ST_OVER,
            ST_WON:     if (w_start_edge) w_next = ST_IDLE;
`ifdef GAME_SEQUENCER_PAUSE_EN
            ST_PAUSED:  if (w_pause_edge) w_next = ST_PLAY;
`endif
            default:    w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_lives <= LIVES_INIT;
            r_en    <= 1'b0;
            r_resp  <= 1'b0;
            r_over  <= 1'b0;
            r_won   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= (w_next == ST_PLAY);
            r_resp  <= (w_next == ST_RESPAWN);
            r_over  <= (w_next == ST_OVER);
            r_won   <= (w_next == ST_WON);

            if (r_state == ST_RESPAWN)
                r_cnt <= 8'd0;
            else if (r_state == ST_SERVE && tick && r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;

            if (w_next == ST_IDLE)
                r_lives <= LIVES_INIT;
            else if (r_state == ST_LOST && r_lives != 2'd0)
                r_lives <= r_lives - 2'd1;
        end
    end

    assign ballEnable  = r_en;
    assign ballRespawn = r_resp;
    assign lives       = r_lives;
    assign gameOver    = r_over;
    assign gameWon     = r_won;
    assign gameState   = r_state;

    logic w_unused;
    assign w_unused = w_pause_edge;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with SERVE_TICKS=4, LIVES=3.
// Pause steps run only when GAME_SEQUENCER_PAUSE_EN is defined.
module tb_game_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_RESP = 3'd1, S_SERVE = 3'd2,
                           S_PLAY = 3'd3, S_LOST = 3'd4, S_OVER = 3'd5,
                           S_WON = 3'd6, S_PAUSED = 3'd7;

    logic       clk = 1'b0;
    logic       reset, tick, start, ballOut, bricksCleared;
    logic       ballEnable, ballRespawn, gameOver, gameWon;
    logic [1:0] lives;
    logic [2:0] gameState;
`ifdef GAME_SEQUENCER_PAUSE_EN
    logic       pause;
`endif

    int total = 0;
    int bad   = 0;

    game_sequencer #(.LIVES(3), .SERVE_TICKS(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .ballOut(ballOut), .bricksCleared(bricksCleared),
`ifdef GAME_SEQUENCER_PAUSE_EN
        .pause(pause),
`endif
        .ballEnable(ballEnable), .ballRespawn(ballRespawn), .lives(lives),
        .gameOver(gameOver), .gameWon(gameWon), .gameState(gameState)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] lv,
                             input logic en, input logic rsp, input logic ov, input logic wn);
        check({tag, ".state"},   {5'd0, gameState}, {5'd0, st});
        check({tag, ".lives"},   {6'd0, lives},     {6'd0, lv});
        check({tag, ".en"},      {7'd0, ballEnable}, {7'd0, en});
        check({tag, ".respawn"}, {7'd0, ballRespawn}, {7'd0, rsp});
        check({tag, ".over"},    {7'd0, gameOver},  {7'd0, ov});
        check({tag, ".won"},     {7'd0, gameWon},   {7'd0, wn});
    endtask

    task automatic one_tick();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    // From RESPAWN: one cycle to SERVE, then four ticks reach PLAY.
    task automatic serve_to_play(input string tag);
        cyc();
        check({tag, ".serve"}, {5'd0, gameState}, {5'd0, S_SERVE});
        repeat (3) one_tick();
        check({tag, ".serve3"}, {7'd0, ballEnable}, 8'd0);
        tick = 1'b1; cyc();
        check({tag, ".play_en"}, {7'd0, ballEnable}, 8'd1);
        tick = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; cyc();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; start = 1'b1; ballOut = 1'b0; bricksCleared = 1'b0;
`ifdef GAME_SEQUENCER_PAUSE_EN
        pause = 1'b0;
`endif
        cyc(); cyc();
        check_all("reset", S_IDLE, 2'd3, 0, 0, 0, 0);

        // start held through reset release: no edge
        reset = 1'b1;
        repeat (3) cyc();
        check_all("held_start", S_IDLE, 2'd3, 0, 0, 0, 0);
        start = 1'b0; cyc();
        check("released", {5'd0, gameState}, {5'd0, S_IDLE});

        // ballOut/bricksCleared ignored in IDLE
        ballOut = 1'b1; bricksCleared = 1'b1; cyc();
        check("idle_ignore", {5'd0, gameState}, {5'd0, S_IDLE});
        ballOut = 1'b0; bricksCleared = 1'b0;

        press_start();
        check_all("respawn1", S_RESP, 2'd3, 0, 1, 0, 0);
        serve_to_play("g1");
        check_all("play1", S_PLAY, 2'd3, 1, 0, 0, 0);

        // lose life 1
        ballOut = 1'b1; cyc();
        check_all("lost1", S_LOST, 2'd3, 0, 0, 0, 0);
        ballOut = 1'b0; cyc();
        check_all("resp2", S_RESP, 2'd2, 0, 1, 0, 0);
        serve_to_play("g2");
        ballOut = 1'b1; cyc(); ballOut = 1'b0; cyc();
        check_all("resp3", S_RESP, 2'd1, 0, 1, 0, 0);
        serve_to_play("g3");
        ballOut = 1'b1; cyc();
        check_all("lost3", S_LOST, 2'd1, 0, 0, 0, 0);
        cyc();
        check_all("over", S_OVER, 2'd0, 0, 0, 1, 0);
        repeat (3) cyc();
        check_all("over_hold", S_OVER, 2'd0, 0, 0, 1, 0);
        ballOut = 1'b0;

        press_start();
        check_all("over_idle", S_IDLE, 2'd3, 0, 0, 0, 0);
        cyc();

        // simultaneous ballOut and bricksCleared: WON takes priority
        press_start();
        serve_to_play("g4");
        ballOut = 1'b1; bricksCleared = 1'b1; cyc();
        check_all("won", S_WON, 2'd3, 0, 0, 0, 1);
        ballOut = 1'b0; bricksCleared = 1'b0; cyc(); cyc();
        check_all("won_hold", S_WON, 2'd3, 0, 0, 0, 1);
        press_start();
        check("won_idle", {5'd0, gameState}, {5'd0, S_IDLE});
        cyc();

        // reset mid-SERVE with tick and start active
        press_start();
        cyc();
        one_tick(); one_tick();
        check("mid_serve", {5'd0, gameState}, {5'd0, S_SERVE});
        reset = 1'b0; tick = 1'b1; start = 1'b1; cyc();
        check_all("serve_reset", S_IDLE, 2'd3, 0, 0, 0, 0);
        reset = 1'b1; tick = 1'b0; start = 1'b0; cyc();
        press_start();
        check("resp_after_rst", {5'd0, gameState}, {5'd0, S_RESP});
        serve_to_play("g5");

        // reset while in LOST
        ballOut = 1'b1; cyc();
        check("lost_pre_rst", {5'd0, gameState}, {5'd0, S_LOST});
        reset = 1'b0; cyc();
        ballOut = 1'b0;
        check_all("lost_reset", S_IDLE, 2'd3, 0, 0, 0, 0);
        reset = 1'b1; cyc();

`ifdef GAME_SEQUENCER_PAUSE_EN
        press_start();
        serve_to_play("g6");
        pause = 1'b1; cyc();
        check_all("paused", S_PAUSED, 2'd3, 0, 0, 0, 0);
        pause = 1'b0; ballOut = 1'b1; cyc(); cyc();
        check_all("paused_hold", S_PAUSED, 2'd3, 0, 0, 0, 0);
        pause = 1'b1; cyc();
        check_all("unpause", S_PLAY, 2'd3, 1, 0, 0, 0);
        pause = 1'b0; cyc();
        check("unpause_lost", {5'd0, gameState}, {5'd0, S_LOST});
        ballOut = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
